mem_txn_responder: RTL and testbench
====================================

Name: mem_txn_responder

Overview:
- Memory-side responder for the core's memory-transaction interface. It accepts requests qualified by memory_transaction, mem_write, address, 128-bit data and byte enablers.
- It sequences a synchronous single-port 128-bit RAM with fixed read latency, then returns read_data_bus with a one-cycle data_ready pulse.
- It also serves a low-priority read-only video port (HDMI scanout) on the same RAM port.
- It replaces the free-running wait FSM between the core and data RAM.

Parameters:
ADDR_W, 19, RAM word-address width (byte address bits used by the core)
DATA_W, 128, bus data width; byte-enable width is DATA_W/8
READ_LATENCY, 1, RAM clock cycles from address issue to valid ram_read_data; legal range 1..7

Ports:
clock  in  1  single clock, rising edge
async_reset  in  1  asynchronous, active-low reset
memory_transaction  in  1  core request valid; held with stable fields until data_ready
mem_write  in  1  1 = write, 0 = read
address  in  32  core byte address (ALU result)
data_in  in  DATA_W  core write data
byte_enablers  in  DATA_W/8  per-byte write enables
read_data_bus  out  DATA_W  core read data, registered
data_ready  out  1  one-cycle completion pulse to core
bus_error  out  1  one-cycle pulse with data_ready when address[31:ADDR_W] != 0
vid_req  in  1  video read request, level, held until vid_valid
vid_address  in  ADDR_W  video read address
vid_valid  out  1  one-cycle pulse, vid_data valid
vid_data  out  DATA_W  video read data, registered
ram_address  out  ADDR_W  RAM address
ram_data_out  out  DATA_W  RAM write data
ram_byte_enablers  out  DATA_W/8  RAM byte enables
ram_write_enable  out  1  RAM write strobe
ram_read_data  in  DATA_W  RAM read data

Behaviour:
- Reset values (async_reset low): state IDLE, and every output plus latched request register at 0, including read_data_bus and vid_data.
  - Reset mid-transaction aborts it. No data_ready is issued and no RAM write completes after reset asserts.
- States: IDLE, CORE_WR, CORE_RD, CORE_DONE, VID_RD, VID_DONE, ERR_DONE.
- IDLE: on a clock edge with memory_transaction=1, latch address, data_in, byte_enablers and mem_write into the request register.
  - Address out of range: go to ERR_DONE.
  - mem_write=1: go to CORE_WR.
  - Otherwise: go to CORE_RD.
  - If memory_transaction=0 and vid_req=1, latch vid_address and go to VID_RD.
  - Core has strict priority when both request in the same cycle.
- CORE_WR: one cycle with ram_write_enable=1 and latched address, data and byte enables driven; then CORE_DONE.
  - Core write latency is 2 cycles from the accepting edge to the data_ready cycle.
- CORE_RD: drive the latched address with ram_write_enable=0. A 3-bit counter loads READ_LATENCY-1 on entry and decrements.
  - When it reaches 0, capture ram_read_data into read_data_bus and go to CORE_DONE.
  - Core read latency is READ_LATENCY+1 cycles to data_ready.
- CORE_DONE: data_ready=1 for exactly one cycle, then IDLE. memory_transaction is ignored in this cycle.
  - A new request held high is accepted at the next IDLE edge; back-to-back rate is one transaction per (latency+1) cycles.
- ERR_DONE: data_ready=1 and bus_error=1 for one cycle, read_data_bus forced to 0, no RAM access; then IDLE.
- VID_RD / VID_DONE: same timing as CORE_RD / CORE_DONE, but using vid_address, capturing into vid_data and pulsing vid_valid.
  - A video read in flight is never preempted. A core request arriving during VID_RD waits and is accepted in IDLE after VID_DONE.
- read_data_bus holds its value until the next core read or error completes; writes leave it unchanged. vid_data holds similarly.
- ram_write_enable is high only in CORE_WR; in all other states it is 0 and ram_byte_enablers is 0.
- Address mapping: ram_address = address[ADDR_W-1:0], passed through without shifting.

Decomposition:
- Package mem_txn_pkg holds the state enum type, DATA_W/BE_W defaults and the latency-counter width constant.
- One natural sub-module, mem_txn_latency_counter: load, decrement and zero flag.
- The FSM and request/data registers stay in the top module.

Test Plan:
- Reset: hold async_reset=0 with random inputs, then release -> all outputs 0, state IDLE, no ram_write_enable.
- Core write of addr 0x0000_0040, data 0x...DEADBEEF, BE 0x000F -> ram_write_enable high exactly 1 cycle with ram_address=0x40 and BE=0x000F; data_ready pulses 2 cycles after the accepting edge; read_data_bus unchanged.
- Core read, READ_LATENCY=3, RAM model returning 0x1234 -> data_ready 4 cycles after accept, read_data_bus=0x1234 and held after MT drops.
- Core read of 0x0008_0000 (bit 19 set) -> data_ready and bus_error together after 1 cycle, read_data_bus=0, no RAM access.
- vid_req and memory_transaction both rise in the same cycle -> core served first, then the video read; vid_valid pulses with the correct data and data_ready is never lost.
- async_reset asserted during CORE_RD -> no data_ready pulse, outputs zero; a fresh read after release completes normally.

Source files
------------

// File: rtl/mem_txn_pkg.sv
// Shared types and constants for the memory-transaction responder.
// Holds the FSM state encoding, default bus widths and the latency-counter width.
package mem_txn_pkg;

    localparam int DEF_DATA_W = 128;
    localparam int DEF_BE_W   = DEF_DATA_W / 8;
    localparam int CNT_W      = 3;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CORE_WR   = 3'd1,
        CORE_RD   = 3'd2,
        CORE_DONE = 3'd3,
        VID_RD    = 3'd4,
        VID_DONE  = 3'd5,
        ERR_DONE  = 3'd6
    } state_t;

endpackage

// File: rtl/mem_txn_latency_counter.sv
// Down-counter that times the RAM read latency.
// Loads a start value, decrements while enabled and flags zero.
module mem_txn_latency_counter
    import mem_txn_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/mem_txn_responder.sv
// Memory-side responder: sequences a single-port RAM for core reads/writes
// and a low-priority video read port, returning one-cycle completion pulses.
module mem_txn_responder
    import mem_txn_pkg::*;
#(
    parameter int ADDR_W       = 19,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int READ_LATENCY = 1
) (
    input  logic                clock,
    input  logic                async_reset,
    input  logic                memory_transaction,
    input  logic                mem_write,
    input  logic [31:0]         address,
    input  logic [DATA_W-1:0]   data_in,
    input  logic [DATA_W/8-1:0] byte_enablers,
    output logic [DATA_W-1:0]   read_data_bus,
    output logic                data_ready,
    output logic                bus_error,
    input  logic                vid_req,
    input  logic [ADDR_W-1:0]   vid_address,
    output logic                vid_valid,
    output logic [DATA_W-1:0]   vid_data,
    output logic [ADDR_W-1:0]   ram_address,
    output logic [DATA_W-1:0]   ram_data_out,
    output logic [DATA_W/8-1:0] ram_byte_enablers,
    output logic                ram_write_enable,
    input  logic [DATA_W-1:0]   ram_read_data,
    output state_t              dbg_state
);

    // Handshake: a requester raises its request (memory_transaction or vid_req)
    // with stable fields and holds it until its one-cycle completion pulse
    // (data_ready or vid_valid); the request is taken on an IDLE clock edge.

    localparam int               BE_W     = DATA_W / 8;
    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(READ_LATENCY - 1);

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_vid_addr;
    logic [DATA_W-1:0] r_data;
    logic [BE_W-1:0]   r_be;
    logic              r_write;
    logic [DATA_W-1:0] r_rdata;
    logic [DATA_W-1:0] r_vdata;
    logic              w_load;
    logic              w_dec;
    logic              w_zero;
    logic              w_oor;
    logic              w_core_acc;

    assign w_oor      = |address[31:ADDR_W];
    assign w_core_acc = (r_state == IDLE) && memory_transaction;
    assign w_dec      = (r_state == CORE_RD) || (r_state == VID_RD);

    mem_txn_latency_counter u_lat_cnt (
        .i_clk      (clock),
        .i_rst_n    (async_reset),
        .i_load     (w_load),
        .i_load_val (LAT_LOAD),
        .i_dec      (w_dec),
        .o_zero     (w_zero)
    );

    always_ff @(posedge clock or negedge async_reset) begin
        if (!async_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Core always wins over video when both ask on the same IDLE edge.
    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        case (r_state)
            IDLE: begin
                if (memory_transaction) begin
                    if (w_oor) begin
                        w_next = ERR_DONE;
                    end else if (mem_write) begin
                        w_next = CORE_WR;
                    end else begin
                        w_next = CORE_RD;
                        w_load = 1'b1;
                    end
                end else if (vid_req) begin
                    w_next = VID_RD;
                    w_load = 1'b1;
                end
            end
            CORE_WR:   w_next = CORE_DONE;
            CORE_RD:   if (w_zero) w_next = CORE_DONE;
            CORE_DONE: w_next = IDLE;
            VID_RD:    if (w_zero) w_next = VID_DONE;
            VID_DONE:  w_next = IDLE;
            ERR_DONE:  w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge async_reset) begin
        if (!async_reset) begin
            r_addr     <= '0;
            r_vid_addr <= '0;
            r_data     <= '0;
            r_be       <= '0;
            r_write    <= 1'b0;
            r_rdata    <= '0;
            r_vdata    <= '0;
        end else begin
            if (w_core_acc) begin
                r_addr  <= address[ADDR_W-1:0];
                r_data  <= data_in;
                r_be    <= byte_enablers;
                r_write <= mem_write;
                if (w_oor) begin
                    r_rdata <= '0;
                end
            end else if ((r_state == IDLE) && vid_req) begin
                r_vid_addr <= vid_address;
            end
            if ((r_state == CORE_RD) && w_zero) begin
                r_rdata <= ram_read_data;
            end
            if ((r_state == VID_RD) && w_zero) begin
                r_vdata <= ram_read_data;
            end
        end
    end

    // RAM port is idle (all zero) outside the access states.
    always_comb begin
        ram_address       = '0;
        ram_data_out      = '0;
        ram_byte_enablers = '0;
        ram_write_enable  = 1'b0;
        case (r_state)
            CORE_WR: begin
                ram_address       = r_addr;
                ram_data_out      = r_data;
                ram_byte_enablers = r_be;
                ram_write_enable  = r_write;
            end
            CORE_RD: ram_address = r_addr;
            VID_RD:  ram_address = r_vid_addr;
            default: ;
        endcase
    end

    assign data_ready    = (r_state == CORE_DONE) || (r_state == ERR_DONE);
    assign bus_error     = (r_state == ERR_DONE);
    assign vid_valid     = (r_state == VID_DONE);
    assign read_data_bus = r_rdata;
    assign vid_data      = r_vdata;
    assign dbg_state     = r_state;

endmodule

// File: tb/tb_mem_txn_responder.sv
// Directed bench for mem_txn_responder with a RAM model, a shadow memory
// and response scoreboards for the core and video ports.
module tb_mem_txn_responder;
  import mem_txn_pkg::*;

  localparam int ADDR_W = 19;
  localparam int DATA_W = 128;
  localparam int BE_W   = 16;
  localparam int RL     = 3;

  logic              clock = 1'b0;
  logic              async_reset;
  logic              memory_transaction;
  logic              mem_write;
  logic [31:0]       address;
  logic [DATA_W-1:0] data_in;
  logic [BE_W-1:0]   byte_enablers;
  logic [DATA_W-1:0] read_data_bus;
  logic              data_ready;
  logic              bus_error;
  logic              vid_req;
  logic [ADDR_W-1:0] vid_address;
  logic              vid_valid;
  logic [DATA_W-1:0] vid_data;
  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_data_out;
  logic [BE_W-1:0]   ram_byte_enablers;
  logic              ram_write_enable;
  logic [DATA_W-1:0] ram_read_data;
  state_t            dbg_state;

  int total = 0;
  int bad   = 0;

  logic [DATA_W:0]   exp_q[$];
  logic [DATA_W-1:0] vid_q[$];
  logic [DATA_W-1:0] shadow [0:255];
  logic [DATA_W-1:0] ram [0:255];
  logic [ADDR_W-1:0] rd_a1;
  bit                ram_loaded = 1'b0;
  logic [DATA_W-1:0] exp_rd;

  int                we_cnt = 0;
  logic [ADDR_W-1:0] we_addr;
  logic [BE_W-1:0]   we_be;
  logic [DATA_W-1:0] we_data;

  // ---------------- clock / DUT ----------------
  always #5 clock = ~clock;

  mem_txn_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LATENCY(RL)) dut (
    .clock              (clock),
    .async_reset        (async_reset),
    .memory_transaction (memory_transaction),
    .mem_write          (mem_write),
    .address            (address),
    .data_in            (data_in),
    .byte_enablers      (byte_enablers),
    .read_data_bus      (read_data_bus),
    .data_ready         (data_ready),
    .bus_error          (bus_error),
    .vid_req            (vid_req),
    .vid_address        (vid_address),
    .vid_valid          (vid_valid),
    .vid_data           (vid_data),
    .ram_address        (ram_address),
    .ram_data_out       (ram_data_out),
    .ram_byte_enablers  (ram_byte_enablers),
    .ram_write_enable   (ram_write_enable),
    .ram_read_data      (ram_read_data),
    .dbg_state          (dbg_state)
  );

  function automatic logic [DATA_W-1:0] seed_word(input int i);
    if (i == 128) return 128'h1234;
    return {32'hC0DE_0000 + 32'(i), 32'(i) * 32'h0101_0101, 32'h5A5A_5A5A ^ 32'(i), 32'(i)};
  endfunction

  // RAM model: two register stages from address to data (READ_LATENCY=3).
  always @(posedge clock) begin
    if (!ram_loaded) begin
      for (int i = 0; i < 256; i++) ram[i] <= seed_word(i);
      ram_loaded <= 1'b1;
    end else if (ram_write_enable) begin
      for (int b = 0; b < BE_W; b++)
        if (ram_byte_enablers[b]) ram[ram_address[7:0]][8*b +: 8] <= ram_data_out[8*b +: 8];
    end
    rd_a1         <= ram_address;
    ram_read_data <= ram[rd_a1[7:0]];
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [DATA_W:0] obs, input logic [DATA_W:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clock) begin
    if (ram_write_enable) begin
      we_cnt++;
      we_addr = ram_address;
      we_be   = ram_byte_enablers;
      we_data = ram_data_out;
    end
    if (data_ready || bus_error) begin
      if (exp_q.size() == 0) check("unexpected_data_ready", {1'b1, 128'h0}, '0);
      else check("core_resp", {bus_error, read_data_bus}, exp_q.pop_front());
    end
    if (vid_valid) begin
      if (vid_q.size() == 0) check("unexpected_vid_valid", {1'b1, 128'h0}, '0);
      else check("vid_resp", {1'b0, vid_data}, {1'b0, vid_q.pop_front()});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic core_txn(input bit wr, input logic [31:0] a, input logic [DATA_W-1:0] d,
                          input logic [BE_W-1:0] be, input int exp_lat);
    int n;
    logic [7:0] idx;
    idx = a[7:0];
    if (a[31:ADDR_W] != '0) begin
      exp_rd = '0;
      exp_q.push_back({1'b1, exp_rd});
    end else if (wr) begin
      exp_q.push_back({1'b0, exp_rd});
      for (int b = 0; b < BE_W; b++)
        if (be[b]) shadow[idx][8*b +: 8] = d[8*b +: 8];
    end else begin
      exp_rd = shadow[idx];
      exp_q.push_back({1'b0, exp_rd});
    end
    @(negedge clock);
    memory_transaction = 1'b1;
    mem_write          = wr;
    address            = a;
    data_in            = d;
    byte_enablers      = be;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!data_ready && n < 20);
    memory_transaction = 1'b0;
    mem_write          = 1'b0;
    check("core_latency", 129'(n), 129'(exp_lat));
  endtask

  task automatic vid_txn(input logic [ADDR_W-1:0] a);
    int n;
    logic [7:0] idx;
    idx = a[7:0];
    vid_q.push_back(shadow[idx]);
    @(negedge clock);
    vid_req     = 1'b1;
    vid_address = a;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!vid_valid && n < 20);
    vid_req = 1'b0;
    check("vid_latency", 129'(n), 129'(RL + 1));
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_state"}, 129'(dbg_state), 129'(IDLE));
    check({tag, "_rdbus"}, {1'b0, read_data_bus}, '0);
    check({tag, "_viddata"}, {1'b0, vid_data}, '0);
    check({tag, "_pulses"}, 129'({data_ready, bus_error, vid_valid, ram_write_enable}), '0);
    check({tag, "_ramport"}, 129'({ram_address, ram_byte_enablers}), '0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n, dr_k, vv_k, we0;
    logic [DATA_W-1:0] hold_val;

    for (int i = 0; i < 256; i++) shadow[i] = seed_word(i);
    exp_rd = '0;
    async_reset = 1'b0;
    memory_transaction = 1'b0; mem_write = 1'b0; address = '0; data_in = '0;
    byte_enablers = '0; vid_req = 1'b0; vid_address = '0;

    // Reset held with random inputs
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      memory_transaction = 1'($urandom_range(0, 1));
      mem_write          = 1'($urandom_range(0, 1));
      address            = $urandom;
      data_in            = {$urandom, $urandom, $urandom, $urandom};
      byte_enablers      = 16'($urandom_range(0, 65535));
      vid_req            = 1'($urandom_range(0, 1));
      vid_address        = 19'($urandom_range(0, 524287));
      #1 check_idle_outputs("in_reset");
    end
    memory_transaction = 1'b0; mem_write = 1'b0; vid_req = 1'b0; address = '0;
    @(negedge clock);
    async_reset = 1'b1;
    @(negedge clock);
    check_idle_outputs("after_reset");

    // Core write: one RAM strobe, data_ready two cycles after accept
    we0 = we_cnt;
    core_txn(1'b1, 32'h0000_0040, 128'h0123_4567_89AB_CDEF_0F1E_2D3C_DEAD_BEEF, 16'h000F, 2);
    check("wr_strobe_count", 129'(we_cnt - we0), 129'(1));
    check("wr_ram_address", 129'(we_addr), 129'(19'h40));
    check("wr_ram_be", 129'(we_be), 129'(16'h000F));
    check("wr_ram_data_low", 129'(we_data[31:0]), 129'(32'hDEAD_BEEF));

    // Core read of preloaded word, then held after request drops
    core_txn(1'b0, 32'h0000_0080, '0, '0, RL + 1);
    repeat (3) @(negedge clock);
    check("rd_hold", {1'b0, read_data_bus}, {1'b0, 128'h1234});

    // Read back the partially written word
    core_txn(1'b0, 32'h0000_0040, '0, '0, RL + 1);

    // Out-of-range read and write: error after one cycle, no RAM access
    we0 = we_cnt;
    core_txn(1'b0, 32'h0008_0000, '0, '0, 1);
    core_txn(1'b1, 32'h8000_0040, {4{32'hFFFF_FFFF}}, 16'hFFFF, 1);
    check("err_no_ram_write", 129'(we_cnt - we0), 129'(0));
    core_txn(1'b0, 32'h0000_0040, '0, '0, RL + 1);

    // Write leaves read_data_bus untouched
    hold_val = read_data_bus;
    core_txn(1'b1, 32'h0000_0011, {4{32'h1357_9BDF}}, 16'hF0F0, 2);
    check("wr_keeps_rdbus", {1'b0, read_data_bus}, {1'b0, hold_val});

    // Video-only read
    vid_txn(19'h80);
    vid_txn(19'h11);

    // Core and video request in the same cycle: core first
    exp_rd = shadow[8'h40];
    exp_q.push_back({1'b0, exp_rd});
    vid_q.push_back(shadow[8'h11]);
    @(negedge clock);
    memory_transaction = 1'b1; mem_write = 1'b0; address = 32'h40;
    vid_req = 1'b1; vid_address = 19'h11;
    n = 0; dr_k = 0; vv_k = 0;
    while ((dr_k == 0 || vv_k == 0) && n < 40) begin
      @(negedge clock);
      n++;
      if (data_ready && dr_k == 0) begin dr_k = n; memory_transaction = 1'b0; end
      if (vid_valid && vv_k == 0) begin vv_k = n; vid_req = 1'b0; end
    end
    memory_transaction = 1'b0; vid_req = 1'b0;
    check("prio_core_cycle", 129'(dr_k), 129'(RL + 1));
    check("prio_vid_cycle", 129'(vv_k), 129'(2 * RL + 3));

    // Randomised in-range traffic
    for (int t = 0; t < 8; t++) begin
      bit wr;
      wr = 1'($urandom_range(0, 1));
      core_txn(wr, 32'($urandom_range(0, 255)), {$urandom, $urandom, $urandom, $urandom},
               16'($urandom_range(0, 65535)), wr ? 2 : RL + 1);
    end

    // Reset in the middle of a core read
    @(negedge clock);
    memory_transaction = 1'b1; mem_write = 1'b0; address = 32'h80;
    @(negedge clock);
    @(negedge clock);
    check("mid_rd_state", 129'(dbg_state), 129'(CORE_RD));
    async_reset = 1'b0;
    memory_transaction = 1'b0;
    exp_rd = '0;
    #1 check_idle_outputs("mid_rd_reset");
    repeat (3) @(negedge clock);
    async_reset = 1'b1;
    repeat (6) @(negedge clock);
    check("post_reset_rdbus", {1'b0, read_data_bus}, '0);
    core_txn(1'b0, 32'h0000_0080, '0, '0, RL + 1);

    repeat (4) @(negedge clock);
    check("queues_drained", 129'(exp_q.size() + vid_q.size()), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
